ram_dp_pipe: RTL
================

# ram_dp_pipe

Parametrised dual-port simulation main memory: one 32-bit instruction fetch port and one DATA_W-bit load/store port share a single word array. Compared with the single-cycle memory it replaces, it adds configurable read latency, request/valid handshakes, address-window decoding with error responses, and a global stall. It sits below the core's IF and MEM stages. A DPI hook exposes the array to the C++ testbench for program loading.

## Interface
- DATA_W, default 64: data word width; a multiple of 32, at most 128.
- DEPTH_LOG2, default 24: log2 of the number of words in the array.
- BASE_ADDR, default 32'h8000_0000: byte address of word 0.
- LATENCY, default 1: read latency in cycles, legal range 1..4.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_stop  in  1  global stall; freezes acceptance and the response pipeline.
- i_req  in  1  fetch request.
- i_addr  in  32  fetch byte address; must be 4-byte aligned.
- i_rvalid  out  1  fetch response valid.
- i_rdata  out  32  fetched instruction.
- i_err  out  1  fetch error, qualified by i_rvalid.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  byte address; bits [log2(DATA_W/8)-1:0] are ignored.
- d_be  in  DATA_W/8  byte-lane enables, active high; must be contiguous.
- d_wdata  in  DATA_W  store data, right-justified.
- d_rvalid  out  1  load/store response valid.
- d_rdata  out  DATA_W  load data, right-justified and zero-extended.
- d_err  out  1  load/store error, qualified by d_rvalid.

## Operation
- Word index: (addr - BASE_ADDR) >> log2(DATA_W/8).
- In range means BASE_ADDR <= addr < BASE_ADDR + (DATA_W/8)<<DEPTH_LOG2.
- Acceptance: a request is accepted on the rising edge where req=1 and mem_stop=0. There is no back-pressure; every cycle can carry one fetch plus one data op.
- Lane shift: sh = 8 × index of the lowest set bit of d_be. If d_be = 0, sh = 0.
- Store, accepted and in range:
  - Each enabled byte of the array word is set to (d_wdata << sh) in that lane.
  - Disabled bytes keep their old value.
  - The write commits on the acceptance edge.
  - Response: d_rdata = 0, d_err = 0.
- Load, accepted and in range:
  - The array word is sampled on the acceptance edge.
  - Disabled lanes are masked to 0, then the word is shifted right logically by sh.
- Fetch:
  - Lane = i_addr[log2(DATA_W/8)-1:2] selects a 32-bit lane of the word.
  - The word is sampled on the acceptance edge.
- Error cases, for either port:
  - Out of range, or misaligned fetch (i_addr[1:0] != 0): err = 1, rdata = 0, no array write.
  - d_be = 0: the request is treated as a no-op with a normal response and rdata = 0.
- Same-edge collision: a fetch and a store to the same word on one edge return the OLD word to the fetch (read-before-write).
- Array contents are not reset. Initialised array contents come only via DPI.
- Per-port response pipeline: LATENCY stages of {valid, err, data}.
  - Stage 0 loads on the acceptance edge; the stage-0 valid loads the value of req.
  - Stages advance together only while mem_stop = 0.
- Output gating: i_rvalid = last_valid & ~mem_stop, and likewise for d_rvalid, so a response is presented exactly once. rdata/err hold their values during a stall.

## Timing
- Reset, asynchronous: all pipeline valid, err and data bits are cleared immediately, so every output is 0. A request in flight when reset asserts is discarded; a store already committed stays committed.
- Latency: for a request accepted at edge k, rvalid is high in the cycle following edge k+LATENCY-1. With LATENCY=1 the response appears in the cycle after the acceptance edge.
- Throughput: one response per port per unstalled cycle. Back-to-back requests give back-to-back rvalid.
- Stall:
  - mem_stop high for n cycles delays every in-flight response by n cycles.
  - No request is accepted and no store commits while stalled.
  - Responses come out in request order; none are dropped or duplicated.
- RAW ordering: a load accepted on any edge after a store's acceptance edge sees the stored data, regardless of LATENCY.
- Deassertion of reset must be synchronised externally to clk.

## Test plan
- Reset mid-stream: LATENCY=3, three loads in flight, rst pulses asynchronously → all outputs 0 immediately; no rvalid afterwards; memory unchanged.
- Byte store/load: store d_be=8'h10, d_wdata=64'hAB to word 0 (pre-filled 64'h1122334455667788) → word becomes 64'h112233AB55667788. A load with d_be=8'h10 returns 64'hAB; d_be=8'hFF returns the full word.
- Latency and throughput: LATENCY=4, four consecutive fetches at BASE+0/4/8/12 → i_rvalid high on 4 consecutive cycles starting 4 cycles after the first acceptance edge; data lanes in order.
- Stall: LATENCY=2, d_req at edge k, mem_stop high for 3 cycles starting the next cycle → d_rvalid appears exactly once, 3 cycles late, with correct data.
- Errors: load at BASE-8, fetch at BASE+2, store beyond the top of the array → each response has err=1 and rdata=0; the array is unmodified.
- Collision/RAW: fetch and full store to the same word on one edge → fetch returns old data; a load on the next edge returns new data.

Source files
------------

// File: rtl/ram_dp_pipe.sv
// Dual-port pipelined simulation memory: one 32-bit fetch port and one
// DATA_W-bit load/store port over a shared word array, each port with a
// LATENCY-deep {valid, err, data} response pipeline frozen by mem_stop.
module ram_dp_pipe #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH_LOG2 = 24,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_stop,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err
);

  localparam int NB  = DATA_W / 8;
  localparam int NL  = DATA_W / 32;
  localparam int OFF = $clog2(NB);
  localparam logic [32:0] MEM_BYTES = 33'(NB) << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic [31:0]           i_offs;
  logic                  i_bad;
  logic [DEPTH_LOG2-1:0] i_idx;
  logic [DATA_W-1:0]     i_word;
  int                    i_lane;
  logic [31:0]           i_data;

  logic [31:0]           d_offs;
  logic                  d_bad;
  logic [DEPTH_LOG2-1:0] d_idx;
  int                    d_sh;
  logic [DATA_W-1:0]     d_mask;
  logic [DATA_W-1:0]     d_store;
  logic [DATA_W-1:0]     d_data;

  logic              i_v_q [LATENCY];
  logic              i_e_q [LATENCY];
  logic [31:0]       i_d_q [LATENCY];
  logic              d_v_q [LATENCY];
  logic              d_e_q [LATENCY];
  logic [DATA_W-1:0] d_d_q [LATENCY];

  // Fetch decode: window check, alignment check, 32-bit lane select from the old word
  always_comb begin
    i_offs = i_addr - BASE_ADDR;
    i_bad  = (i_addr < BASE_ADDR) || ({1'b0, i_offs} >= MEM_BYTES) || (i_offs[1:0] != 2'b00);
    i_idx  = i_offs[OFF +: DEPTH_LOG2];
    i_word = mem[i_idx];
    i_lane = int'((i_offs >> 2) % NL);
    i_data = '0;
    for (int l = 0; l < NL; l++) begin
      if (i_lane == l) i_data = i_word[32*l +: 32];
    end
  end

  // Data decode: lane shift from lowest enabled byte, masked/right-justified load, left-shifted store
  always_comb begin
    d_offs = d_addr - BASE_ADDR;
    d_bad  = (d_addr < BASE_ADDR) || ({1'b0, d_offs} >= MEM_BYTES);
    d_idx  = d_offs[OFF +: DEPTH_LOG2];
    d_sh   = 0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (d_be[b]) d_sh = b * 8;
    end
    d_mask = '0;
    for (int b = 0; b < NB; b++) begin
      d_mask[8*b +: 8] = {8{d_be[b]}};
    end
    d_store = d_wdata << d_sh;
    d_data  = d_we ? '0 : ((mem[d_idx] & d_mask) >> d_sh);
  end

  // Array write: commits on the acceptance edge; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (d_req && d_we && !mem_stop && !d_bad) begin
      for (int b = 0; b < NB; b++) begin
        if (d_be[b]) mem[d_idx][8*b +: 8] <= d_store[8*b +: 8];
      end
    end
  end

  // Fetch response pipeline, frozen while mem_stop is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        i_v_q[s] <= 1'b0;
        i_e_q[s] <= 1'b0;
        i_d_q[s] <= '0;
      end
    end else if (!mem_stop) begin
      i_v_q[0] <= i_req;
      i_e_q[0] <= i_req & i_bad;
      i_d_q[0] <= (i_req && !i_bad) ? i_data : '0;
      for (int s = 1; s < LATENCY; s++) begin
        i_v_q[s] <= i_v_q[s-1];
        i_e_q[s] <= i_e_q[s-1];
        i_d_q[s] <= i_d_q[s-1];
      end
    end
  end

  // Load/store response pipeline, frozen while mem_stop is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        d_v_q[s] <= 1'b0;
        d_e_q[s] <= 1'b0;
        d_d_q[s] <= '0;
      end
    end else if (!mem_stop) begin
      d_v_q[0] <= d_req;
      d_e_q[0] <= d_req & d_bad;
      d_d_q[0] <= (d_req && !d_bad) ? d_data : '0;
      for (int s = 1; s < LATENCY; s++) begin
        d_v_q[s] <= d_v_q[s-1];
        d_e_q[s] <= d_e_q[s-1];
        d_d_q[s] <= d_d_q[s-1];
      end
    end
  end

  // Valid is gated by the stall so each response is presented exactly once
  assign i_rvalid = i_v_q[LATENCY-1] & ~mem_stop;
  assign i_rdata  = i_d_q[LATENCY-1];
  assign i_err    = i_e_q[LATENCY-1];
  assign d_rvalid = d_v_q[LATENCY-1] & ~mem_stop;
  assign d_rdata  = d_d_q[LATENCY-1];
  assign d_err    = d_e_q[LATENCY-1];

endmodule
